// File: rtl/ipu_input_ctrl.sv
// Front end of the input processing unit. It synchronises and debounces the place button,
// validates the switch coordinate, and holds ipu_int with that coordinate until proc sends int_ack.
module ipu_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COORD_MAX       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic [3:0] sw_coord,
  input  logic       int_ack,
  output logic       ipu_int,
  output logic [3:0] grid_coord,
  output logic       coord_err
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Handshake: ipu_int is a level request. It rises with grid_coord already valid and
  // stays up until int_ack is seen in PEND; it falls on that same edge.
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PEND, RELEASE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          sync1, btn_s;
  logic          load_coord, err_next;
  logic          coord_ok;

  assign coord_ok = (int'(sw_coord) <= COORD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      btn_s      <= 1'b0;
      state      <= RELEASE;
      cnt        <= '0;
      grid_coord <= 4'd0;
      coord_err  <= 1'b0;
    end else begin
      sync1     <= btn_in;
      btn_s     <= sync1;
      state     <= state_next;
      cnt       <= cnt_next;
      coord_err <= err_next;
      if (load_coord) grid_coord <= sw_coord;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_coord = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
      end
      DEBOUNCE: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (coord_ok) begin
            load_coord = 1'b1;
            state_next = PEND;
          end else begin
            err_next   = 1'b1;
            state_next = RELEASE;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      PEND: begin
        if (int_ack) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        // Any high sample restarts the low-time requirement, so one press fires once.
        if (btn_s) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = RELEASE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ipu_int = (state == PEND);
  end

endmodule

// File: tb/tb_ipu_input_ctrl.sv
// Bench for ipu_input_ctrl at DEBOUNCE_CYCLES=4. A run-length reference model is checked
// every cycle, directed scenarios cover press, bounce, illegal coordinate, ack and reset, and random traffic follows.
module tb_ipu_input_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic [3:0] sw_coord = 4'd0;
  logic       int_ack = 1'b0;
  logic       ipu_int;
  logic [3:0] grid_coord;
  logic       coord_err;

  int checks = 0;
  int errors = 0;

  ipu_input_ctrl #(.DEBOUNCE_CYCLES(D), .COORD_MAX(8)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .sw_coord(sw_coord), .int_ack(int_ack),
    .ipu_int(ipu_int), .grid_coord(grid_coord), .coord_err(coord_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the synchroniser is a two-deep delay line. The controller is tracked as
  // runs of high/low synchronised samples, plus armed/pending flags.
  bit         m_s1, m_s2, m_pending, m_armed, m_err;
  int         m_low, m_high;
  logic [3:0] m_coord;

  always @(posedge clk) begin
    bit bs;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_pending = 0; m_armed = 0; m_err = 0;
      m_low = 0; m_high = 0; m_coord = 4'd0;
    end else begin
      bs = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_in;
      m_err = 0;
      if (m_pending) begin
        if (int_ack) begin
          m_pending = 0; m_armed = 0; m_low = 0;
        end
      end else if (!m_armed) begin
        m_low = bs ? 0 : m_low + 1;
        if (m_low == D) begin
          m_armed = 1; m_high = 0;
        end
      end else begin
        m_high = bs ? m_high + 1 : 0;
        if (m_high == D + 1) begin
          if (sw_coord <= 4'd8) begin
            m_coord = sw_coord; m_pending = 1;
          end else begin
            m_err = 1;
          end
          m_armed = 0; m_low = 0;
        end
      end
    end
  end

  int  rises = 0, falls = 0, err_pulses = 0;
  logic prev_int = 1'b0;

  always @(negedge clk) begin
    check_eq("model_ipu_int", ipu_int, m_pending);
    check_eq("model_grid_coord", grid_coord, m_coord);
    check_eq("model_coord_err", coord_err, m_err);
    check_eq("int_err_exclusive", ipu_int & coord_err, 0);
    if (ipu_int === 1'b1 && prev_int === 1'b0) rises++;
    if (ipu_int === 1'b0 && prev_int === 1'b1) falls++;
    if (coord_err === 1'b1) err_pulses++;
    prev_int = ipu_int;
  end

  task automatic cyc(input bit b, input logic [3:0] sw, input bit ack, input int n);
    repeat (n) begin
      btn_in = b; sw_coord = sw; int_ack = ack;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, r0, f0, e0;
    bit found;

    // T1: basic press, latency and acknowledge
    rst = 1'b1;
    cyc(0, 0, 0, 2);
    check_eq("rst_ipu_int", ipu_int, 0);
    check_eq("rst_grid_coord", grid_coord, 0);
    check_eq("rst_coord_err", coord_err, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 6);
    btn_in = 1'b1; sw_coord = 4'd5;
    found = 0; lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ipu_int === 1'b1) begin
        found = 1; lat = i;
        break;
      end
    end
    check_eq("t1_int_seen", found, 1);
    check_eq("t1_latency", lat, D + 2);
    check_eq("t1_grid_coord", grid_coord, 5);
    cyc(1, 5, 0, 13);
    cyc(1, 5, 1, 1);
    check_eq("t1_ack_fall", ipu_int, 0);
    cyc(0, 5, 0, 8);

    // T2: bounce rejected
    r0 = rises; e0 = err_pulses;
    cyc(1, 5, 0, 2); cyc(0, 5, 0, 1); cyc(1, 5, 0, 2); cyc(0, 5, 0, 8);
    check_eq("t2_no_int", rises - r0, 0);
    check_eq("t2_no_err", err_pulses - e0, 0);

    // T3: illegal coordinate
    r0 = rises; e0 = err_pulses;
    cyc(1, 9, 0, 10); cyc(0, 9, 0, 8);
    check_eq("t3_err_once", err_pulses - e0, 1);
    check_eq("t3_no_int", rises - r0, 0);
    check_eq("t3_grid_kept", grid_coord, 5);

    // T4: activity during PEND ignored, then fresh press
    cyc(1, 5, 0, 10);
    check_eq("t4_pend", ipu_int, 1);
    cyc(0, 3, 0, 3); cyc(1, 3, 0, 10);
    check_eq("t4_grid_frozen", grid_coord, 5);
    check_eq("t4_still_pend", ipu_int, 1);
    cyc(0, 3, 1, 1); cyc(0, 3, 0, 8); cyc(1, 3, 0, 10);
    check_eq("t4_new_int", ipu_int, 1);
    check_eq("t4_new_grid", grid_coord, 3);

    // T5: ack held in PEND gives a single fall; ack while idle does nothing
    r0 = rises; f0 = falls;
    cyc(1, 3, 1, 3); cyc(1, 3, 0, 15);
    check_eq("t5_single_fall", falls - f0, 1);
    check_eq("t5_no_rearm", rises - r0, 0);
    cyc(0, 3, 0, 8); cyc(0, 3, 1, 4);
    check_eq("t5_idle_ack", ipu_int, 0);
    cyc(1, 7, 0, 10);
    check_eq("t5_press_after", ipu_int, 1);
    check_eq("t5_grid", grid_coord, 7);

    // T6: reset in PEND with button held
    rst = 1'b1;
    cyc(1, 7, 0, 2);
    rst = 1'b0;
    check_eq("t6_int_dropped", ipu_int, 0);
    check_eq("t6_grid_zero", grid_coord, 0);
    r0 = rises;
    cyc(1, 7, 0, 15);
    check_eq("t6_held_no_int", rises - r0, 0);
    cyc(0, 7, 0, 6); cyc(1, 2, 0, 10);
    check_eq("t6_repress_int", ipu_int, 1);
    check_eq("t6_repress_grid", grid_coord, 2);
    cyc(0, 2, 1, 1); cyc(0, 0, 0, 8);

    // Random traffic against the model
    for (int s = 0; s < 300; s++) begin
      bit b, a;
      logic [3:0] sw;
      int n;
      b  = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 12);
      sw = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      a  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 59) == 0);
      cyc(b, sw, a, rst ? 1 : n);
      rst = 1'b0;
    end
    cyc(0, 0, 0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
